ascon_word_loader: RTL and testbench

- Upstream stage of the 1-block Ascon-128a encrypt wrapper.
- Accepts a word-serial host stream over a valid/ready handshake and assembles the four 128-bit operands SK, N, A and P.
- Presents the operands to the encrypt wrapper, holds them stable for the wrapper's fixed latency, then pulses a done strobe marking when C/T are valid at the wrapper outputs.

---
 rtl/ascon_pkg.sv | 17 +
 rtl/ascon_loader_fsm.sv | 95 +++++++++
 rtl/ascon_word_loader.sv | 83 ++++++++
 tb/tb_ascon_word_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Shared constants for the Ascon-128a word loader: FSM encoding, operand width, field indices.
// Handshake: a word transfers on a rising CLK edge where in_valid && in_ready; the host holds data/last stable until then.
package ascon_pkg;

  localparam int OPER_W     = 128;
  localparam int NUM_FIELDS = 4;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] FIELD_SK = 2'd0;
  localparam logic [1:0] FIELD_N  = 2'd1;
  localparam logic [1:0] FIELD_A  = 2'd2;
  localparam logic [1:0] FIELD_P  = 2'd3;

endpackage

// File: rtl/ascon_loader_fsm.sv
// Loader control: state register, word counter and latency counter.
// Emits the operand write strobe with field/slice select and the frame status outputs.
module ascon_loader_fsm
  import ascon_pkg::*;
#(
  parameter int WORD_W   = 32,
  parameter int CORE_LAT = 4
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic                                 in_valid,
  input  logic                                 in_last,
  output logic                                 in_ready,
  output logic                                 wr_en,
  output logic [1:0]                           wr_field,
  output logic [$clog2(OPER_W/WORD_W)-1:0]     wr_slice,
  output logic                                 vec_valid,
  output logic                                 core_done,
  output logic                                 frame_err,
  output logic [1:0]                           state_dbg
);

  localparam int NW      = 512 / WORD_W;
  localparam int WPF     = OPER_W / WORD_W;
  localparam int CNT_W   = $clog2(NW);
  localparam int SLICE_W = $clog2(WPF);
  localparam int LAT_W   = $clog2(CORE_LAT) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NW - 1);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(CORE_LAT - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             err_q, err_d;
  logic             xfer;

  assign xfer = in_valid && (state_q == ST_LOAD);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      lat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      err_q   <= err_d;
    end
  end

  // A framing error is any disagreement between in_last and "this is word NW-1".
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    err_d   = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (xfer) begin
          err_d = in_last != (cnt_q == CNT_LAST);
          if (cnt_q == CNT_LAST) begin
            state_d = ST_HOLD;
            lat_d   = LAT_INIT;
            cnt_d   = '0;
          end else if (in_last) begin
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (lat_q == '0) state_d = ST_DONE;
        else             lat_d   = lat_q - 1'b1;
      end
      ST_DONE: state_d = ST_LOAD;
      default: state_d = ST_LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_LOAD);
    vec_valid = (state_q == ST_HOLD) || (state_q == ST_DONE);
    core_done = (state_q == ST_DONE);
    frame_err = err_q;
    wr_en     = xfer;
    wr_field  = cnt_q[CNT_W-1 -: 2];
    wr_slice  = cnt_q[SLICE_W-1:0];
    state_dbg = state_q;
  end

endmodule

// File: rtl/ascon_word_loader.sv
// Word-serial operand loader for the Ascon-128a encrypt wrapper; assembles SK/N/A/P MS-word first.
// Define ASCON_LOADER_BSWAP_EN to byte-reverse each host word before storage (little-endian host).
module ascon_word_loader
  import ascon_pkg::*;
#(
  parameter int WORD_W   = 32,
  parameter int CORE_LAT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [OPER_W-1:0] SK,
  output logic [OPER_W-1:0] N,
  output logic [OPER_W-1:0] A,
  output logic [OPER_W-1:0] P,
  output logic              vec_valid,
  output logic              core_done,
  output logic              frame_err
);

  localparam int WPF     = OPER_W / WORD_W;
  localparam int SLICE_W = $clog2(WPF);

  logic               wr_en;
  logic [1:0]         wr_field;
  logic [SLICE_W-1:0] wr_slice;
  logic [1:0]         fsm_state;
  logic [WORD_W-1:0]  word_in;
  logic [OPER_W-1:0]  oper_q [NUM_FIELDS];

  ascon_loader_fsm #(
    .WORD_W   (WORD_W),
    .CORE_LAT (CORE_LAT)
  ) u_fsm (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_field  (wr_field),
    .wr_slice  (wr_slice),
    .vec_valid (vec_valid),
    .core_done (core_done),
    .frame_err (frame_err),
    .state_dbg (fsm_state)
  );

`ifdef ASCON_LOADER_BSWAP_EN
  always_comb begin
    word_in = '0;
    for (int b = 0; b < WORD_W / 8; b++) begin
      word_in[b*8 +: 8] = in_data[WORD_W-8-b*8 +: 8];
    end
  end
`else
  assign word_in = in_data;
`endif

  // Operands are only ever written while loading, which keeps them frozen for the wrapper.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int f = 0; f < NUM_FIELDS; f++) oper_q[f] <= '0;
    end else if (wr_en && fsm_state == ST_LOAD) begin
      for (int f = 0; f < NUM_FIELDS; f++) begin
        for (int s = 0; s < WPF; s++) begin
          if (wr_field == 2'(f) && wr_slice == SLICE_W'(s)) begin
            oper_q[f][OPER_W-1-s*WORD_W -: WORD_W] <= word_in;
          end
        end
      end
    end
  end

  assign SK = oper_q[FIELD_SK];
  assign N  = oper_q[FIELD_N];
  assign A  = oper_q[FIELD_A];
  assign P  = oper_q[FIELD_P];

endmodule

// File: tb/tb_ascon_word_loader.sv
// Self-checking bench for ascon_word_loader: directed frames plus random frames against a frame-level model.
// Build with ASCON_LOADER_BSWAP_EN defined to exercise the byte-reversed storage path.
module tb_ascon_word_loader;

  localparam int W        = 32;
  localparam int CORE_LAT = 4;
  localparam int NW       = 512 / W;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [127:0]  SK, N, A, P;
  logic          vec_valid, core_done, frame_err;

  int checks   = 0;
  int failures = 0;

  ascon_word_loader #(.WORD_W(W), .CORE_LAT(CORE_LAT)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .SK        (SK),
    .N         (N),
    .A         (A),
    .P         (P),
    .vec_valid (vec_valid),
    .core_done (core_done),
    .frame_err (frame_err)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] stored(input logic [W-1:0] d);
`ifdef ASCON_LOADER_BSWAP_EN
    logic [W-1:0] r;
    for (int b = 0; b < W / 8; b++) r[b*8 +: 8] = d[W-8-b*8 +: 8];
    return r;
`else
    return d;
`endif
  endfunction

  // ---------------- behavioural model ----------------
  // exp_q collects the words of the frame in progress; a complete frame is the
  // 512-bit concatenation of its words, SK being the top 128 bits.
  logic [W-1:0] exp_q[$];
  logic [511:0] m_frame = '0;
  int           m_since = -1;   // cycles since the final word was taken; -1 = loading
  bit           m_err = 1'b0;
  bit           m_zero = 1'b1;  // no word stored since reset
  bit           ready_prev;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      exp_q.delete();
      m_frame = '0;
      m_since = -1;
      m_err   = 1'b0;
      m_zero  = 1'b1;
    end else begin
      ready_prev = (m_since < 0);
      m_err = 1'b0;
      if (m_since >= 0) begin
        m_since++;
        if (m_since == CORE_LAT + 2) m_since = -1;
      end
      if (ready_prev && in_valid) begin
        m_zero = 1'b0;
        exp_q.push_back(stored(in_data));
        if (exp_q.size() == NW) begin
          for (int i = 0; i < NW; i++) m_frame = (m_frame << W) | 512'(exp_q[i]);
          m_err   = !in_last;
          m_since = 1;
          exp_q.delete();
        end else if (in_last) begin
          m_err = 1'b1;
          exp_q.delete();
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge CLK) begin
    if (!RST) begin
      check("in_ready", 128'(in_ready), 128'(m_since < 0));
      check("vec_valid", 128'(vec_valid), 128'(m_since >= 1));
      check("core_done", 128'(core_done), 128'(m_since == CORE_LAT + 1));
      check("frame_err", 128'(frame_err), 128'(m_err));
      if (m_since >= 1) begin
        check("SK", SK, m_frame[511:384]);
        check("N",  N,  m_frame[383:256]);
        check("A",  A,  m_frame[255:128]);
        check("P",  P,  m_frame[127:0]);
      end else if (m_zero) begin
        check("oper_zero", SK | N | A | P, 128'h0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [W-1:0] d, input bit last);
    bit taken = 1'b0;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    for (int t = 0; t < 64; t++) begin
      @(negedge CLK);
      if (in_ready) begin
        taken = 1'b1;
        break;
      end
    end
    if (!taken) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=no_ready required=ready");
    end
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = W'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame_seq(input logic [W-1:0] base, input bit last_ok);
    for (int k = 0; k < NW; k++) send_word(base + W'(k), last_ok && (k == NW - 1));
  endtask

  // Counts cycles until core_done (bounded) and how many of them had vec_valid.
  task automatic wait_done(output int n, output int vv);
    n = 0;
    vv = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge CLK);
      n++;
      if (vec_valid) vv++;
      if (core_done) break;
    end
    if (!core_done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=%0d required=%0d", n, CORE_LAT + 1);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, vv, abort_at;
    bit miss;

    // reset state
    repeat (2) @(negedge CLK);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_vec_valid", 128'(vec_valid), 128'd0);
    check("rst_core_done", 128'(core_done), 128'd0);
    check("rst_frame_err", 128'(frame_err), 128'd0);
    check("rst_oper", SK | N | A | P, 128'h0);
    RST = 1'b0;
    idle(1);

    // nominal frame 0..15
    send_frame_seq(W'(0), 1'b1);
    wait_done(n, vv);
    check("nom_latency", 128'(n), 128'(CORE_LAT + 1));
    check("nom_vec_cycles", 128'(vv), 128'(CORE_LAT + 1));
`ifdef ASCON_LOADER_BSWAP_EN
    check("nom_SK", SK, 128'h00000000_01000000_02000000_03000000);
    check("nom_P",  P,  128'h0C000000_0D000000_0E000000_0F000000);
`else
    check("nom_SK", SK, 128'h00000000_00000001_00000002_00000003);
    check("nom_P",  P,  128'h0000000C_0000000D_0000000E_0000000F);
`endif

    // backpressure: next frame's first word offered during HOLD
    send_frame_seq(W'(32'h100), 1'b1);
    send_word(W'(32'hA5A5A5A5), 1'b0);
    check("bp_first_word", 128'(SK[127:96]), 128'h A5A5A5A5);
    for (int k = 1; k < NW; k++) send_word(W'(32'h200 + k), k == NW - 1);
    wait_done(n, vv);
    check("bp_latency", 128'(n), 128'(CORE_LAT + 1));

    // early in_last on word 6
    for (int k = 0; k <= 6; k++) send_word(W'(32'h300 + k), k == 6);
    @(negedge CLK);
    check("early_err", 128'(frame_err), 128'd1);
    check("early_no_vec", 128'(vec_valid), 128'd0);
    idle(1);
    send_frame_seq(W'(32'h400), 1'b1);
    wait_done(n, vv);
    check("after_early_SK", SK, {stored(32'h400), stored(32'h401), stored(32'h402), stored(32'h403)});

    // missing in_last on word 15
    send_frame_seq(W'(32'h500), 1'b0);
    @(negedge CLK);
    check("miss_err", 128'(frame_err), 128'd1);
    check("miss_vec", 128'(vec_valid), 128'd1);
    wait_done(n, vv);
    check("miss_latency", 128'(n), 128'(CORE_LAT));

    // async reset in HOLD cycle 2
    send_frame_seq(W'(32'h600), 1'b1);
    @(negedge CLK);
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check("hold_rst_vec", 128'(vec_valid), 128'd0);
    check("hold_rst_done", 128'(core_done), 128'd0);
    check("hold_rst_oper", SK | N | A | P, 128'h0);
    @(negedge CLK);
    #2;
    RST = 1'b0;
    @(negedge CLK);
    check("hold_rst_ready", 128'(in_ready), 128'd1);
    idle(CORE_LAT + 4);

`ifdef ASCON_LOADER_BSWAP_EN
    send_word(W'(32'h00112233), 1'b0);
    check("bswap_word0", 128'(SK[127:96]), 128'h33221100);
    for (int k = 1; k < NW; k++) send_word(W'($urandom), k == NW - 1);
    idle(CORE_LAT + 3);
`endif

    // random frames: gaps, early aborts, missing last
    for (int f = 0; f < 30; f++) begin
      abort_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, NW - 2)) : -1;
      miss     = ($urandom_range(0, 4) == 0);
      for (int k = 0; k < NW; k++) begin
        if (abort_at >= 0 && k > abort_at) break;
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        send_word(W'($urandom), (k == abort_at) || (k == NW - 1 && !miss));
      end
      if ($urandom_range(0, 1) == 0) idle($urandom_range(0, CORE_LAT + 3));
    end
    idle(CORE_LAT + 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
